// File: rtl/bp_nonsynth_reset_sequencer_if.sv
// Soft re-reset handshake and per-domain reset outputs of the reset sequencer.
// Member names carry the direction suffix as seen from the sequencer.
interface bp_nonsynth_reset_sequencer_if #(
  parameter int num_channels_p = 4
);
  logic                      soft_reset_v_i;
  logic                      soft_reset_ready_o;
  logic [num_channels_p-1:0] channel_mask_i;
  logic [num_channels_p-1:0] reset_o;
  logic                      assert_en_o;
  logic                      done_o;

  modport slave (
    input  soft_reset_v_i,
    input  channel_mask_i,
    output soft_reset_ready_o,
    output reset_o,
    output assert_en_o,
    output done_o
  );

  modport master (
    output soft_reset_v_i,
    output channel_mask_i,
    input  soft_reset_ready_o,
    input  reset_o,
    input  assert_en_o,
    input  done_o
  );
endinterface

// File: rtl/bp_nonsynth_reset_sequencer.sv
// Staggered multi-domain reset sequencer with assertion enable and handshaked
// soft re-reset of a selectable subset of domains.
module bp_nonsynth_reset_sequencer #(
  parameter int num_channels_p   = 4,
  parameter int hold_cycles_p    = 20,
  parameter int stagger_cycles_p = 4,
  parameter int assert_delay_p   = 1
) (
  input  logic                               clk_i,
  input  logic                               reset_n_i,
  bp_nonsynth_reset_sequencer_if.slave       seq_if
);

  localparam int MaxHS  = (hold_cycles_p > stagger_cycles_p) ? hold_cycles_p : stagger_cycles_p;
  localparam int MaxCnt = (MaxHS > assert_delay_p) ? MaxHS : assert_delay_p;
  localparam int CntW   = $clog2(MaxCnt + 1);
  localparam int IdxW   = (num_channels_p > 1) ? $clog2(num_channels_p) : 1;

  localparam logic [CntW-1:0] HoldLast   = CntW'(hold_cycles_p - 1);
  localparam logic [CntW-1:0] StagLast   = CntW'(stagger_cycles_p - 1);
  localparam logic [CntW-1:0] DelayLast  = CntW'(assert_delay_p - 1);
  localparam logic [IdxW-1:0] LastIdx    = IdxW'(num_channels_p - 1);

  typedef enum logic [1:0] {
    S_HOLD,
    S_RELEASE,
    S_SETTLE,
    S_RUN
  } state_e;

  state_e                    state_q, state_d;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic [IdxW-1:0]           idx_q, idx_d;
  logic [num_channels_p-1:0] mask_q, mask_d;
  logic [num_channels_p-1:0] reset_q, reset_d;
  logic                      run_q, run_d;
  logic                      accept;

  assign accept = run_q & seq_if.soft_reset_v_i;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= S_HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      mask_q  <= '1;
      reset_q <= '1;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      mask_q  <= mask_d;
      reset_q <= reset_d;
      run_q   <= run_d;
    end
  end

  // Each release slot clears its channel on entry; the last channel's slot
  // hands straight over to SETTLE so done follows the final release by assert_delay_p.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    mask_d  = mask_q;
    reset_d = reset_q;
    run_d   = run_q;

    case (state_q)
      S_HOLD: begin
        if (cnt_q == HoldLast) begin
          cnt_d = '0;
          idx_d = '0;
          if (mask_q[0]) reset_d[0] = 1'b0;
          state_d = (num_channels_p == 1) ? S_SETTLE : S_RELEASE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_RELEASE: begin
        if (cnt_q == StagLast) begin
          cnt_d = '0;
          idx_d = idx_q + 1'b1;
          for (int k = 0; k < num_channels_p; k++) begin
            if ((IdxW'(k) == idx_d) && mask_q[k]) reset_d[k] = 1'b0;
          end
          if (idx_d == LastIdx) state_d = S_SETTLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_SETTLE: begin
        if (cnt_q == DelayLast) begin
          cnt_d   = '0;
          run_d   = 1'b1;
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_RUN: begin
        // An empty mask is accepted but leaves every domain running.
        if (accept) begin
          mask_d = seq_if.channel_mask_i;
          if (|seq_if.channel_mask_i) begin
            reset_d = reset_q | seq_if.channel_mask_i;
            run_d   = 1'b0;
            cnt_d   = '0;
            state_d = S_HOLD;
          end
        end
      end

      default: begin
        state_d = S_HOLD;
        cnt_d   = '0;
      end
    endcase
  end

  assign seq_if.reset_o            = reset_q;
  assign seq_if.soft_reset_ready_o = run_q;
  assign seq_if.assert_en_o        = run_q;
  assign seq_if.done_o             = run_q;

endmodule

// File: tb/tb_bp_nonsynth_reset_sequencer.sv
// Bench for the reset sequencer: a default-parameter instance and a minimal
// single-channel instance, both compared every cycle against a timing model.
module tb_bp_nonsynth_reset_sequencer;

  logic clk  = 1'b0;
  logic rst0 = 1'b0;
  logic rst1 = 1'b0;
  logic chk0 = 1'b0;
  logic chk1 = 1'b0;

  int cmpCount  = 0;
  int missCount = 0;

  always #5 clk = ~clk;

  bp_nonsynth_reset_sequencer_if #(.num_channels_p(4)) if0 ();
  bp_nonsynth_reset_sequencer_if #(.num_channels_p(1)) if1 ();

  bp_nonsynth_reset_sequencer dut0 (
    .clk_i     (clk),
    .reset_n_i (rst0),
    .seq_if    (if0)
  );

  bp_nonsynth_reset_sequencer #(
    .num_channels_p   (1),
    .hold_cycles_p    (1),
    .stagger_cycles_p (1),
    .assert_delay_p   (1)
  ) dut1 (
    .clk_i     (clk),
    .reset_n_i (rst1),
    .seq_if    (if1)
  );

  // Model: edges elapsed since the start of the current sequence decide everything.
  int         mT     [2] = '{0, 0};
  logic [3:0] mMask  [2] = '{4'hF, 4'h1};
  logic [3:0] mStart [2] = '{4'hF, 4'h1};

  function automatic int pN(input int i);    return (i == 0) ? 4 : 1;  endfunction
  function automatic int pHold(input int i); return (i == 0) ? 20 : 1; endfunction
  function automatic int pStag(input int i); return (i == 0) ? 4 : 1;  endfunction
  function automatic int pDly(input int i);  return 1;                 endfunction
  function automatic logic [3:0] chMask(input int i); return (i == 0) ? 4'hF : 4'h1; endfunction

  function automatic logic [3:0] expReset(input int i);
    logic [3:0] r;
    r = mStart[i];
    for (int k = 0; k < pN(i); k++)
      if (mMask[i][k] && (mT[i] >= pHold(i) + k * pStag(i))) r[k] = 1'b0;
    return r;
  endfunction

  function automatic logic expRun(input int i);
    return mT[i] >= pHold(i) + (pN(i) - 1) * pStag(i) + pDly(i);
  endfunction

  task automatic modelReset(input int i);
    mT[i]     = 0;
    mMask[i]  = chMask(i);
    mStart[i] = chMask(i);
  endtask

  task automatic modelEdge(input int i, input logic v, input logic [3:0] m);
    logic [3:0] mm;
    mm = m & chMask(i);
    if (v && expRun(i) && (mm != 4'h0)) begin
      mStart[i] = expReset(i) | mm;
      mMask[i]  = mm;
      mT[i]     = 0;
    end else if (mT[i] < 100000) begin
      mT[i] = mT[i] + 1;
    end
  endtask

  always @(posedge clk or negedge rst0) begin
    if (!rst0) modelReset(0);
    else       modelEdge(0, if0.soft_reset_v_i, if0.channel_mask_i);
  end

  always @(posedge clk or negedge rst1) begin
    if (!rst1) modelReset(1);
    else       modelEdge(1, if1.soft_reset_v_i, 4'(if1.channel_mask_i));
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmpCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int i, input logic v, input logic [3:0] m);
    @(negedge clk);
    if (i == 0) begin
      if0.soft_reset_v_i = v;
      if0.channel_mask_i = m;
    end else begin
      if1.soft_reset_v_i = v;
      if1.channel_mask_i = m[0];
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (chk0) begin
      checkOutput("model0 reset_o",   32'(if0.reset_o),            32'(expReset(0)));
      checkOutput("model0 assert_en", 32'(if0.assert_en_o),        32'(expRun(0)));
      checkOutput("model0 done",      32'(if0.done_o),             32'(expRun(0)));
      checkOutput("model0 ready",     32'(if0.soft_reset_ready_o), 32'(expRun(0)));
    end
    if (chk1) begin
      checkOutput("model1 reset_o",   32'(if1.reset_o),            32'(expReset(1)));
      checkOutput("model1 done",      32'(if1.done_o),             32'(expRun(1)));
      checkOutput("model1 ready",     32'(if1.soft_reset_ready_o), 32'(expRun(1)));
    end
  end

  task automatic seq0();
    if0.soft_reset_v_i = 1'b0;
    if0.channel_mask_i = 4'h0;
    repeat (3) @(posedge clk);
    #1 checkOutput("reset state reset_o", 32'(if0.reset_o), 32'h0F);
    checkOutput("reset state done", 32'(if0.done_o), 32'h0);
    chk0 = 1'b1;
    @(negedge clk) rst0 = 1'b1;

    repeat (20) @(posedge clk);
    #1 checkOutput("T1 edge20 reset_o", 32'(if0.reset_o), 32'h0E);
    repeat (4) @(posedge clk);
    #1 checkOutput("T1 edge24 reset_o", 32'(if0.reset_o), 32'h0C);
    repeat (8) @(posedge clk);
    #1 checkOutput("T1 edge32 reset_o", 32'(if0.reset_o), 32'h00);
    checkOutput("T1 edge32 done", 32'(if0.done_o), 32'h0);
    @(posedge clk);
    #1 checkOutput("T1 edge33 done", 32'(if0.done_o), 32'h1);
    checkOutput("T1 edge33 ready", 32'(if0.soft_reset_ready_o), 32'h1);

    applyStimulus(0, 1'b1, 4'b0101);
    @(posedge clk);
    #1 checkOutput("T2 accept reset_o", 32'(if0.reset_o), 32'h05);
    checkOutput("T2 accept done", 32'(if0.done_o), 32'h0);
    if0.soft_reset_v_i = 1'b0;
    repeat (20) @(posedge clk);
    #1 checkOutput("T2 A+20 reset_o", 32'(if0.reset_o), 32'h04);
    repeat (8) @(posedge clk);
    #1 checkOutput("T2 A+28 reset_o", 32'(if0.reset_o), 32'h00);
    repeat (4) @(posedge clk);
    #1 checkOutput("T2 A+32 done", 32'(if0.done_o), 32'h0);
    @(posedge clk);
    #1 checkOutput("T2 A+33 done", 32'(if0.done_o), 32'h1);

    applyStimulus(0, 1'b1, 4'h0);
    @(posedge clk);
    #1 checkOutput("T3 zero mask reset_o", 32'(if0.reset_o), 32'h00);
    checkOutput("T3 zero mask assert_en", 32'(if0.assert_en_o), 32'h1);
    if0.soft_reset_v_i = 1'b0;

    @(negedge clk) rst0 = 1'b0;
    @(negedge clk) rst0 = 1'b1;
    repeat (26) @(posedge clk);
    #2 rst0 = 1'b0;
    #1 checkOutput("T4 async reset_o", 32'(if0.reset_o), 32'h0F);
    checkOutput("T4 async assert_en", 32'(if0.assert_en_o), 32'h0);
    @(negedge clk) rst0 = 1'b1;
    repeat (20) @(posedge clk);
    #1 checkOutput("T4 replay edge20 reset_o", 32'(if0.reset_o), 32'h0E);
    repeat (13) @(posedge clk);
    #1 checkOutput("T4 replay edge33 done", 32'(if0.done_o), 32'h1);

    applyStimulus(0, 1'b1, 4'hF);
    @(posedge clk);
    #1 checkOutput("T5 accept reset_o", 32'(if0.reset_o), 32'h0F);
    repeat (33) @(posedge clk);
    #1 checkOutput("T5 held v done", 32'(if0.done_o), 32'h1);
    @(posedge clk);
    #1 checkOutput("T5 reaccept reset_o", 32'(if0.reset_o), 32'h0F);
    checkOutput("T5 reaccept done", 32'(if0.done_o), 32'h0);
    applyStimulus(0, 1'b0, 4'h0);
    repeat (34) @(posedge clk);

    for (int n = 0; n < 700; n++) begin
      applyStimulus(0, ($urandom_range(0, 5) == 0), 4'($urandom_range(0, 15)));
      rst0 = ($urandom_range(0, 199) != 0);
    end
    applyStimulus(0, 1'b0, 4'h0);
    rst0 = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic seq1();
    if1.soft_reset_v_i = 1'b0;
    if1.channel_mask_i = 1'b0;
    repeat (3) @(posedge clk);
    chk1 = 1'b1;
    @(negedge clk) rst1 = 1'b1;
    @(posedge clk);
    #1 checkOutput("T6 edge1 reset_o", 32'(if1.reset_o), 32'h0);
    checkOutput("T6 edge1 done", 32'(if1.done_o), 32'h0);
    @(posedge clk);
    #1 checkOutput("T6 edge2 done", 32'(if1.done_o), 32'h1);

    applyStimulus(1, 1'b1, 4'h1);
    @(posedge clk);
    #1 checkOutput("T6 b2b accept1 reset_o", 32'(if1.reset_o), 32'h1);
    @(posedge clk);
    #1 checkOutput("T6 b2b release reset_o", 32'(if1.reset_o), 32'h0);
    checkOutput("T6 b2b no early accept", 32'(if1.done_o), 32'h0);
    @(posedge clk);
    #1 checkOutput("T6 b2b done", 32'(if1.done_o), 32'h1);
    @(posedge clk);
    #1 checkOutput("T6 b2b accept2 reset_o", 32'(if1.reset_o), 32'h1);
    repeat (20) @(posedge clk);

    for (int n = 0; n < 400; n++) begin
      applyStimulus(1, ($urandom_range(0, 2) == 0), 4'($urandom_range(0, 1)));
      rst1 = ($urandom_range(0, 99) != 0);
    end
    applyStimulus(1, 1'b0, 4'h0);
    rst1 = 1'b1;
  endtask

  initial begin
    fork
      seq0();
      seq1();
    join
    repeat (2) @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", cmpCount, missCount);
    $finish;
  end

endmodule
